// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-bus transaction per load/store,
// with load extension, alignment checking and a bus timeout.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_read_type,
    input  logic [3:0]  mem_write_mask,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err_misaligned,
    output logic        err_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [2:0] RD_BYTE  = 3'd0;
    localparam logic [2:0] RD_HALF  = 3'd1;
    localparam logic [2:0] RD_WORD  = 3'd2;
    localparam logic [2:0] RD_B_U   = 3'd3;
    localparam logic [2:0] RD_H_U   = 3'd4;
    localparam logic [3:0] WR_NONE  = 4'b0000;
    localparam logic [3:0] WR_HALF  = 4'b0011;
    localparam logic [3:0] WR_WORD  = 4'b1111;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  rtype_q;
    logic [1:0]  lane_q;
    logic        start;
    logic        is_store;
    logic        misaligned;
    logic [31:0] wdata;

    assign start    = issue && (mem_op != OP_NONE);
    assign is_store = (mem_op == OP_STORE);
    assign bus_req  = (state == REQ);
    assign done     = (state == DONE);
    assign lsu_busy = !rst && ((state == REQ) || ((state == IDLE) && start));

    always_comb begin
        misaligned = 1'b0;
        if (is_store) begin
            misaligned = ((mem_write_mask == WR_HALF) && addr[0]) ||
                         ((mem_write_mask == WR_WORD) && (addr[1:0] != 2'b00));
        end else begin
            misaligned = (((mem_read_type == RD_HALF) || (mem_read_type == RD_H_U)) && addr[0]) ||
                         ((mem_read_type == RD_WORD) && (addr[1:0] != 2'b00));
        end
    end

    always_comb begin
        wdata = {4{store_data[7:0]}};
        if (mem_write_mask == WR_WORD)
            wdata = store_data;
        else if (mem_write_mask == WR_HALF)
            wdata = {2{store_data[15:0]}};
    end

    function automatic logic [31:0] extend(input logic [2:0]  rt,
                                           input logic [1:0]  lane,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> {lane, 3'b000});
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (rt)
            RD_BYTE: extend = {{24{b[7]}}, b};
            RD_B_U:  extend = {24'd0, b};
            RD_HALF: extend = {{16{h[15]}}, h};
            RD_H_U:  extend = {16'd0, h};
            default: extend = rd;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            rtype_q        <= '0;
            lane_q         <= '0;
            load_data      <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wstrb      <= '0;
            bus_wdata      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        rtype_q <= mem_read_type;
                        lane_q  <= addr[1:0];
                        if (misaligned) begin
                            err_misaligned <= 1'b1;
                            state          <= DONE;
                        end else if (is_store && (mem_write_mask == WR_NONE)) begin
                            state <= DONE;
                        end else begin
                            bus_we    <= is_store;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wstrb <= is_store ? (mem_write_mask << addr[1:0]) : 4'b0000;
                            bus_wdata <= is_store ? wdata : 32'd0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 32'd1;
                    // ack on the limit cycle still completes normally
                    if (bus_ack) begin
                        if (!bus_we)
                            load_data <= extend(rtype_q, lane_q, bus_rdata);
                        state <= DONE;
                    end else if ((TIMEOUT_CYCLES != 0) &&
                                 (cnt == 32'(TIMEOUT_CYCLES - 1))) begin
                        err_timeout <= 1'b1;
                        load_data   <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    err_misaligned <= 1'b0;
                    err_timeout    <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
